// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the HI/LO multiply unit
package mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   localparam int CALC_STEPS = 4;

   // SPECIAL (alu_op) function codes
   localparam logic [5:0] FUNC_MFHI  = 6'h10;
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MFLO  = 6'h12;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;

   // SPECIAL2 (mul_op) function codes
   localparam logic [5:0] FUNC_MADD  = 6'h00;
   localparam logic [5:0] FUNC_MADDU = 6'h01;
   localparam logic [5:0] FUNC_MUL   = 6'h02;
   localparam logic [5:0] FUNC_MSUB  = 6'h04;
   localparam logic [5:0] FUNC_MSUBU = 6'h05;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one 32x8 partial product added into a 64-bit accumulator
module mul_step (
   input  logic [63:0] acc_in,
   input  logic [31:0] a,
   input  logic [7:0]  b_byte,
   input  logic [1:0]  idx,
   output logic [63:0] acc_out
);

   logic [39:0] pp;

   assign pp      = {8'b0, a} * {32'b0, b_byte};
   assign acc_out = acc_in + ({24'b0, pp} << {idx, 3'b000});

endmodule

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - multi-cycle multiply/MAC unit owning the HI/LO registers
module mul_hilo_unit
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        alu_op,
   input  logic        mul_op,
   input  logic [5:0]  func,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy,
   output logic        stall
);

   state_t      state, state_next;
   logic [1:0]  cnt;
   logic [63:0] acc, acc_step, prod;
   logic [31:0] mag_a, mag_b, b_shift;
   logic        neg, l_add, l_sub, l_mul;

   logic dec_mulop, dec_signed, dec_add, dec_sub, dec_mul;
   logic dec_mthi, dec_mtlo, dec_mf, recognised, accept;

   always_comb begin
      dec_mulop  = 1'b0;
      dec_signed = 1'b0;
      dec_add    = 1'b0;
      dec_sub    = 1'b0;
      dec_mul    = 1'b0;
      dec_mthi   = 1'b0;
      dec_mtlo   = 1'b0;
      dec_mf     = 1'b0;
      if (alu_op) begin
         case (func)
            FUNC_MULT:  begin dec_mulop = 1'b1; dec_signed = 1'b1; end
            FUNC_MULTU: dec_mulop = 1'b1;
            FUNC_MTHI:  dec_mthi  = 1'b1;
            FUNC_MTLO:  dec_mtlo  = 1'b1;
            FUNC_MFHI,
            FUNC_MFLO:  dec_mf    = 1'b1;
            default:    ;
         endcase
      end
      if (mul_op) begin
         case (func)
            FUNC_MADD:  begin dec_mulop = 1'b1; dec_signed = 1'b1; dec_add = 1'b1; end
            FUNC_MADDU: begin dec_mulop = 1'b1; dec_add = 1'b1; end
            FUNC_MSUB:  begin dec_mulop = 1'b1; dec_signed = 1'b1; dec_sub = 1'b1; end
            FUNC_MSUBU: begin dec_mulop = 1'b1; dec_sub = 1'b1; end
            FUNC_MUL:   begin dec_mulop = 1'b1; dec_signed = 1'b1; dec_mul = 1'b1; end
            default:    ;
         endcase
      end
   end

   assign recognised = dec_mulop | dec_mthi | dec_mtlo | dec_mf;
   assign busy       = (state != S_IDLE);
   assign stall      = busy & start & recognised;
   assign accept     = (state == S_IDLE) & start & dec_mulop;

   // select the multiplier byte for this CALC step
   assign b_shift = mag_b >> {cnt, 3'b000};
   assign prod    = neg ? -acc : acc;

   mul_step u_step (
      .acc_in  (acc),
      .a       (mag_a),
      .b_byte  (b_shift[7:0]),
      .idx     (cnt),
      .acc_out (acc_step)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_CALC;
         S_CALC:  if (cnt == 2'(CALC_STEPS - 1)) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= 2'd0;
         acc          <= 64'd0;
         hi           <= 32'd0;
         lo           <= 32'd0;
         result       <= 32'd0;
         result_valid <= 1'b0;
         mag_a        <= 32'd0;
         mag_b        <= 32'd0;
         neg          <= 1'b0;
         l_add        <= 1'b0;
         l_sub        <= 1'b0;
         l_mul        <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mag_a <= (dec_signed & a[31]) ? -a : a;
                  mag_b <= (dec_signed & b[31]) ? -b : b;
                  neg   <= dec_signed & (a[31] ^ b[31]);
                  l_add <= dec_add;
                  l_sub <= dec_sub;
                  l_mul <= dec_mul;
                  acc   <= 64'd0;
                  cnt   <= 2'd0;
               end else if (start) begin
                  if (dec_mthi) hi <= a;
                  if (dec_mtlo) lo <= a;
               end
            end
            S_CALC: begin
               acc <= acc_step;
               cnt <= cnt + 2'd1;
            end
            S_FIX: begin
               if (l_add)      acc <= {hi, lo} + prod;
               else if (l_sub) acc <= {hi, lo} - prod;
               else            acc <= prod;
            end
            S_DONE: begin
               if (l_mul) begin
                  result       <= acc[31:0];
                  result_valid <= 1'b1;
               end else begin
                  {hi, lo} <= acc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - scoreboard bench for mul_hilo_unit
module tb_mul_hilo_unit;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_MADD  = 6'h00;
   localparam logic [5:0] F_MADDU = 6'h01;
   localparam logic [5:0] F_MUL   = 6'h02;
   localparam logic [5:0] F_MSUB  = 6'h04;
   localparam logic [5:0] F_MSUBU = 6'h05;

   logic        clk = 1'b0;
   logic        rst, start, alu_op, mul_op;
   logic [5:0]  func;
   logic [31:0] a, b;
   logic [31:0] hi, lo, result;
   logic        result_valid, busy, stall;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   typedef struct {
      logic        is_mul;
      logic [63:0] hilo;
      logic [31:0] res;
   } exp_t;
   exp_t exp_q[$];

   mul_hilo_unit dut (
      .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .mul_op(mul_op),
      .func(func), .a(a), .b(b), .hi(hi), .lo(lo), .result(result),
      .result_valid(result_valid), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic idle_inputs();
      start = 1'b0; alu_op = 1'b0; mul_op = 1'b0; func = 6'd0; a = 32'd0; b = 32'd0;
   endtask

   task automatic set_op(input logic alu, input logic mop, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; alu_op = alu; mul_op = mop; func = f; a = x; b = y;
   endtask

   task automatic push_expected(input logic alu, input logic mop, input logic [5:0] f,
                                input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sp;
      logic [63:0] up, hl;
      exp_t e;
      sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      up = {32'd0, x} * {32'd0, y};
      hl = {m_hi, m_lo};
      e.is_mul = 1'b0;
      e.res    = 32'd0;
      if (alu && f == F_MULT)        hl = sp;
      else if (alu && f == F_MULTU)  hl = up;
      else if (mop && f == F_MADD)   hl = hl + sp;
      else if (mop && f == F_MADDU)  hl = hl + up;
      else if (mop && f == F_MSUB)   hl = hl - sp;
      else if (mop && f == F_MSUBU)  hl = hl - up;
      else if (mop && f == F_MUL) begin
         e.is_mul = 1'b1;
         e.res    = sp[31:0];
      end
      e.hilo = hl;
      {m_hi, m_lo} = hl;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(output int busy_cycles);
      busy_cycles = busy ? 1 : 0;
      for (int i = 0; i < 20 && busy; i++) begin
         @(posedge clk); #1;
         if (busy) busy_cycles++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b required 0 within 20 cycles", busy);
      end
   endtask

   task automatic check_completion(input string name, input int busy_cycles, input int busy_req);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, nothing to compare", name);
         return;
      end
      e = exp_q.pop_front();
      if (busy_req > 0) begin
         checks++;
         if (busy_cycles != busy_req) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cycles, busy_req);
         end
      end
      checks++;
      if ({hi, lo} !== e.hilo) begin
         errors++;
         $display("FAIL %s hilo: got %h required %h", name, {hi, lo}, e.hilo);
      end
      if (e.is_mul) begin
         checks++;
         if (result_valid !== 1'b1 || result !== e.res) begin
            errors++;
            $display("FAIL %s result: got valid=%b %h required valid=1 %h",
                     name, result_valid, result, e.res);
         end
         @(posedge clk); #1;
         checks++;
         if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s result_valid pulse: got %b required 0", name, result_valid);
         end
      end
   endtask

   task automatic run_mul(input string name, input logic alu, input logic mop,
                          input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      int bc;
      @(posedge clk); #1;
      set_op(alu, mop, f, x, y);
      push_expected(alu, mop, f, x, y);
      @(posedge clk); #1;
      idle_inputs();
      wait_idle(bc);
      check_completion(name, bc, 6);
   endtask

   task automatic run_mt(input logic [5:0] f, input logic [31:0] x);
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, f, x, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      if (f == F_MTHI) m_hi = x;
      else             m_lo = x;
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
         errors++;
         $display("FAIL mt: got busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
                  busy, hi, lo, m_hi, m_lo);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({hi, lo, result, result_valid, busy, stall} !== 99'd0) begin
         errors++;
         $display("FAIL reset: got hi=%h lo=%h result=%h rv=%b busy=%b stall=%b required all 0",
                  hi, lo, result, result_valid, busy, stall);
      end
   endtask

   task automatic test_mult_neg();
      run_mul("mult_neg", 1'b1, 1'b0, F_MULT, 32'hFFFF_FFFF, 32'd5);
   endtask

   task automatic test_mac();
      run_mt(F_MTHI, 32'd1);
      run_mt(F_MTLO, 32'd2);
      run_mul("maddu", 1'b0, 1'b1, F_MADDU, 32'd3, 32'd4);
      run_mul("msub", 1'b0, 1'b1, F_MSUB, 32'd1, 32'h0000_000F);
      run_mul("madd_neg", 1'b0, 1'b1, F_MADD, 32'hFFFF_FFFE, 32'd3);
      run_mul("msubu", 1'b0, 1'b1, F_MSUBU, 32'h8000_0000, 32'd4);
   endtask

   task automatic test_mul();
      run_mul("mul", 1'b0, 1'b1, F_MUL, 32'd7, 32'hFFFF_FFFD);
   endtask

   task automatic test_extremes();
      run_mul("min_int", 1'b1, 1'b0, F_MULT, 32'h8000_0000, 32'h8000_0000);
      run_mul("max_u", 1'b1, 1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_stall();
      int bc;
      int stall_ok;
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, F_MULTU, 32'h0001_0000, 32'h0003_0000);
      push_expected(1'b1, 1'b0, F_MULTU, 32'h0001_0000, 32'h0003_0000);
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, F_MFHI, 32'd0, 32'd0);
      stall_ok = 1;
      bc = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         bc++;
         if (stall !== 1'b1) stall_ok = 0;
         @(posedge clk); #1;
      end
      checks++;
      if (stall_ok != 1 || bc != 6) begin
         errors++;
         $display("FAIL stall_mfhi: got stall_ok=%0d busy_cycles=%0d required 1 and 6", stall_ok, bc);
      end
      checks++;
      if (stall !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got stall=%b busy=%b required 0 0", stall, busy);
      end
      check_completion("stall_mfhi", 0, 0);
      @(posedge clk); #1;
      idle_inputs();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd3) begin
         errors++;
         $display("FAIL mfhi_accept: got busy=%b hi=%h required 0 00000003", busy, hi);
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, F_MULT, 32'd2, 32'd3);
      push_expected(1'b1, 1'b0, F_MULT, 32'd2, 32'd3);
      @(posedge clk); #1;
      set_op(1'b0, 1'b1, F_MADDU, 32'd1, 32'd1);
      wait_idle(bc);
      check_completion("b2b_first", bc, 6);
      push_expected(1'b0, 1'b1, F_MADDU, 32'd1, 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b required 1", busy);
      end
      wait_idle(bc);
      check_completion("b2b_second", bc, 6);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || {hi, lo} !== 64'd7) begin
         errors++;
         $display("FAIL b2b_once: got busy=%b hilo=%h required 0 %h", busy, {hi, lo}, 64'd7);
      end
   endtask

   task automatic test_ignored();
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, 6'h20, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      set_op(1'b0, 1'b1, 6'h3F, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      idle_inputs();
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
         errors++;
         $display("FAIL ignored: got busy=%b stall=%b hi=%h lo=%h required 0 0 %h %h",
                  busy, stall, hi, lo, m_hi, m_lo);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      set_op(1'b1, 1'b0, F_MULT, 32'h1234_5678, 32'd9);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b1;
      set_op(1'b1, 1'b0, F_MTHI, 32'd5, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      m_hi = 32'd0;
      m_lo = 32'd0;
      checks++;
      if ({hi, lo, result, result_valid, busy, stall} !== 99'd0) begin
         errors++;
         $display("FAIL reset_mid: got hi=%h lo=%h result=%h rv=%b busy=%b stall=%b required all 0",
                  hi, lo, result, result_valid, busy, stall);
      end
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if ({hi, lo} !== 64'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon: got hilo=%h busy=%b required 0 0", {hi, lo}, busy);
      end
      run_mul("after_reset", 1'b1, 1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_mult_neg();
      test_mac();
      test_mul();
      test_extremes();
      test_stall();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
